// File: rtl/lap_ctrl.sv
// rtl/lap_ctrl.sv - stopwatch control FSM with multi-slot lap memory addressing
// Buttons are edge-detected here; the lap register file and display mux live in the datapath.
module lap_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int OVERWRITE = 1,
  parameter int AW        = $clog2(NUM_SLOTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          store,
  input  logic          load,
  input  logic          clr,
  output logic          write,
  output logic          select,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   lap_count,
  output logic          full
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_STOP = 3'd2;
  localparam logic [2:0] S_SAVE = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  localparam logic [AW:0]   SLOTS = (AW+1)'(NUM_SLOTS);
  localparam logic [AW-1:0] LAST  = AW'(NUM_SLOTS - 1);

  logic [2:0]    state, state_nx;
  logic          ret_stop, ret_nx;
  logic          store_d, load_d, clr_d;
  logic          store_rise, load_rise, clr_rise, store_ok;
  logic          do_clear, show_entry, show_step;
  logic [AW-1:0] newest, oldest, rd_prev, wr_next;

  assign store_rise = store & ~store_d;
  assign load_rise  = load & ~load_d;
  assign clr_rise   = clr & ~clr_d;

  assign full     = (lap_count == SLOTS);
  assign store_ok = store_rise & (~full | (OVERWRITE != 0));

  assign write  = (state == S_SAVE);
  assign select = (state == S_SHOW);

  // Addresses wrap modulo NUM_SLOTS, which need not be a power of two.
  assign newest  = (wr_addr == '0) ? LAST : wr_addr - 1'b1;
  assign wr_next = (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
  assign oldest  = full ? wr_addr : '0;
  assign rd_prev = (rd_addr == oldest) ? newest :
                   (rd_addr == '0)     ? LAST   : rd_addr - 1'b1;

  always_comb begin
    state_nx   = state;
    ret_nx     = ret_stop;
    do_clear   = 1'b0;
    show_entry = 1'b0;
    show_step  = 1'b0;
    case (state)
      S_IDLE: if (en) state_nx = S_RUN;
      S_RUN: begin
        if (!en) state_nx = S_STOP;
        else if (store_ok) begin
          state_nx = S_SAVE;
          ret_nx   = 1'b0;
        end
      end
      S_STOP: begin
        if (en) state_nx = S_RUN;
        else if (store_ok) begin
          state_nx = S_SAVE;
          ret_nx   = 1'b1;
        end else if (load_rise && lap_count != '0) begin
          state_nx   = S_SHOW;
          show_entry = 1'b1;
        end else if (clr_rise) do_clear = 1'b1;
      end
      S_SAVE: state_nx = ret_stop ? S_STOP : S_RUN;
      S_SHOW: begin
        if (en) state_nx = S_RUN;
        else if (load_rise) show_step = 1'b1;
        else if (clr_rise) begin
          do_clear = 1'b1;
          state_nx = S_STOP;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ret_stop  <= 1'b0;
      store_d   <= 1'b0;
      load_d    <= 1'b0;
      clr_d     <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      lap_count <= '0;
    end else begin
      state    <= state_nx;
      ret_stop <= ret_nx;
      store_d  <= store;
      load_d   <= load;
      clr_d    <= clr;
      if (do_clear) begin
        wr_addr   <= '0;
        rd_addr   <= '0;
        lap_count <= '0;
      end else begin
        if (state == S_SAVE) begin
          wr_addr <= wr_next;
          if (!full) lap_count <= lap_count + 1'b1;
        end
        if (show_entry) rd_addr <= newest;
        if (show_step) rd_addr <= rd_prev;
      end
    end
  end

endmodule

// File: tb/tb_lap_ctrl.sv
// tb/tb_lap_ctrl.sv - randomized and directed bench for lap_ctrl against a lap-list model
// Instance 0 has OVERWRITE=0, instance 1 has OVERWRITE=1; both share stimulus.
module tb_lap_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_SAVE = 3;
  localparam int M_SHOW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, en = 1'b0, store = 1'b0, load = 1'b0, clr = 1'b0;

  logic [1:0]    write_o, select_o, full_o;
  logic [AW-1:0] wa [2];
  logic [AW-1:0] ra [2];
  logic [AW:0]   lc [2];

  int checks = 0;
  int errors = 0;

  int m_mode [2], m_ret [2], m_wr [2], m_rd [2], m_cnt [2], m_age [2];
  bit m_sd [2], m_ld [2], m_cd [2];
  bit armed = 1'b0;

  always #5 clk = ~clk;

  lap_ctrl #(.NUM_SLOTS(N), .OVERWRITE(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .store(store), .load(load), .clr(clr),
    .write(write_o[0]), .select(select_o[0]), .wr_addr(wa[0]), .rd_addr(ra[0]),
    .lap_count(lc[0]), .full(full_o[0])
  );

  lap_ctrl #(.NUM_SLOTS(N), .OVERWRITE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .store(store), .load(load), .clr(clr),
    .write(write_o[1]), .select(select_o[1]), .wr_addr(wa[1]), .rd_addr(ra[1]),
    .lap_count(lc[1]), .full(full_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a list of up to N laps; in SHOW, 'age' counts back from the newest lap.
  task automatic model_step(input int i);
    bit sr, lr, cr, sok;
    sr = store && !m_sd[i];
    lr = load && !m_ld[i];
    cr = clr && !m_cd[i];
    m_sd[i] = store;
    m_ld[i] = load;
    m_cd[i] = clr;
    if (reset) begin
      m_mode[i] = M_IDLE; m_ret[i] = M_RUN; m_wr[i] = 0; m_rd[i] = 0;
      m_cnt[i] = 0; m_age[i] = 0; m_sd[i] = 0; m_ld[i] = 0; m_cd[i] = 0;
      return;
    end
    sok = sr && (m_cnt[i] < N || i == 1);
    case (m_mode[i])
      M_IDLE: if (en) m_mode[i] = M_RUN;
      M_RUN: begin
        if (!en) m_mode[i] = M_STOP;
        else if (sok) begin m_mode[i] = M_SAVE; m_ret[i] = M_RUN; end
      end
      M_STOP: begin
        if (en) m_mode[i] = M_RUN;
        else if (sok) begin m_mode[i] = M_SAVE; m_ret[i] = M_STOP; end
        else if (lr && m_cnt[i] > 0) begin
          m_mode[i] = M_SHOW;
          m_age[i]  = 0;
          m_rd[i]   = (m_wr[i] + N - 1) % N;
        end else if (cr) begin m_wr[i] = 0; m_rd[i] = 0; m_cnt[i] = 0; end
      end
      M_SAVE: begin
        m_mode[i] = m_ret[i];
        m_wr[i]   = (m_wr[i] + 1) % N;
        m_cnt[i]  = (m_cnt[i] < N) ? m_cnt[i] + 1 : N;
      end
      M_SHOW: begin
        if (en) m_mode[i] = M_RUN;
        else if (lr) begin
          m_age[i] = (m_age[i] + 1) % m_cnt[i];
          m_rd[i]  = (m_wr[i] - 1 - m_age[i] + 2 * N) % N;
        end else if (cr) begin
          m_wr[i] = 0; m_rd[i] = 0; m_cnt[i] = 0; m_mode[i] = M_STOP;
        end
      end
      default: m_mode[i] = M_IDLE;
    endcase
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    if (reset) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("write%0d", i), int'(write_o[i]), int'(m_mode[i] == M_SAVE));
        chk($sformatf("select%0d", i), int'(select_o[i]), int'(m_mode[i] == M_SHOW));
        chk($sformatf("wr_addr%0d", i), int'(wa[i]), m_wr[i]);
        chk($sformatf("rd_addr%0d", i), int'(ra[i]), m_rd[i]);
        chk($sformatf("lap_count%0d", i), int'(lc[i]), m_cnt[i]);
        chk($sformatf("full%0d", i), int'(full_o[i]), int'(m_cnt[i] == N));
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic s, input logic l, input logic c);
    reset = r; en = e; store = s; load = l; clr = c;
    @(negedge clk);
  endtask

  initial begin
    int exp_wa [5] = '{0, 1, 2, 3, 0};
    int exp_rd [3] = '{1, 0, 2};

    // Reset then IDLE, RUN x3, STOP; a store in STOP proves we left IDLE.
    drive(1, 0, 0, 0, 0);
    chk("t1_reset_write", int'(write_o[1]), 0);
    chk("t1_reset_select", int'(select_o[1]), 0);
    chk("t1_reset_lap_count", int'(lc[1]), 0);
    chk("t1_reset_full", int'(full_o[1]), 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0);
      chk("t1_run_write", int'(write_o[1]), 0);
      chk("t1_run_select", int'(select_o[1]), 0);
    end
    drive(0, 0, 0, 0, 0);
    chk("t1_stop_write", int'(write_o[1]), 0);
    drive(0, 0, 1, 0, 0);
    chk("t1_stop_store_write", int'(write_o[1]), 1);
    drive(0, 0, 0, 0, 0);

    // Five store pulses while running; instance 0 refuses the fifth.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, 0);
      chk("t2_write", int'(write_o[1]), 1);
      chk("t2_wr_addr", int'(wa[1]), exp_wa[k]);
      chk("t3_write_noovr", int'(write_o[0]), (k < 4) ? 1 : 0);
      if (k == 4) chk("t3_wr_addr_noovr", int'(wa[0]), 0);
      drive(0, 1, 0, 0, 0);
      chk("t2_lap_count", int'(lc[1]), (k < 3) ? k + 1 : 4);
      chk("t2_full", int'(full_o[1]), (k >= 3) ? 1 : 0);
      chk("t2_select", int'(select_o[1]), 0);
      chk("t3_lap_count_noovr", int'(lc[0]), (k < 3) ? k + 1 : 4);
    end
    chk("t2_wr_addr_final", int'(wa[1]), 1);

    // Three laps, stop, hold load: one step only, then pulses cycle back.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0);
      drive(0, 1, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 1, 0);
      chk("t4_select", int'(select_o[1]), 1);
      chk("t4_rd_held", int'(ra[1]), 2);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      chk("t4_rd_step", int'(ra[1]), exp_rd[k]);
    end

    // Store and load together in STOP: store wins; then clear.
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    chk("t5_write", int'(write_o[1]), 1);
    chk("t5_wr_addr", int'(wa[1]), 3);
    drive(0, 0, 0, 0, 0);
    chk("t5_select", int'(select_o[1]), 0);
    chk("t5_lap_count", int'(lc[1]), 4);
    drive(0, 0, 0, 0, 1);
    chk("t5_clr_count", int'(lc[1]), 0);
    chk("t5_clr_full", int'(full_o[1]), 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("t5_load_empty", int'(select_o[1]), 0);
    drive(0, 0, 0, 0, 0);

    // Reset while in SAVE.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    chk("t6_in_save", int'(write_o[1]), 1);
    drive(1, 1, 1, 0, 0);
    chk("t6_write", int'(write_o[1]), 0);
    chk("t6_lap_count", int'(lc[1]), 0);
    chk("t6_wr_addr", int'(wa[1]), 0);
    chk("t6_select", int'(select_o[1]), 0);

    // Random phase: levels toggle with modest probability so edges and holds both occur.
    for (int k = 0; k < 4000; k++) begin
      logic r, e, s, l, c;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 11) == 0) ? ~en : en;
      s = ($urandom_range(0, 2) == 0) ? ~store : store;
      l = ($urandom_range(0, 2) == 0) ? ~load : load;
      c = ($urandom_range(0, 9) == 0) ? ~clr : clr;
      drive(r, e, s, l, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
